// File: rtl/set_time_ext.sv
// Purpose : HH:MM[:SS] BCD time-setting editor, one digit at a time, up/down stepping with per-digit range wrap.
// Latency : a button edge updates digit/selection on the same clk edge that samples it; done is a 1-cycle registered pulse.
// Backpressure: none; buttons are edge-detected, ignored in IDLE. Optional macro AUTO_REPEAT_EN adds held-button repeat.
module set_time_ext #(
  parameter int SHOW_SECONDS = 1,
  parameter int HOUR_MODE_12 = 0,
  parameter int REPEAT_DELAY = 50,
  parameter int REPEAT_RATE  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       up,
  input  logic       down,
  input  logic       nextDigit,
  input  logic       confirm,
  output logic [3:0] h1,
  output logic [3:0] h0,
  output logic [3:0] min1,
  output logic [3:0] min0,
  output logic [3:0] s1,
  output logic [3:0] s0,
  output logic       editing,
  output logic [2:0] digit_sel,
  output logic       done
);

  typedef enum logic {IDLE, EDIT} state_t;

  localparam logic [2:0] LAST_DIGIT = (SHOW_SECONDS != 0) ? 3'd5 : 3'd3;
  localparam logic [3:0] H1_MAX     = (HOUR_MODE_12 != 0) ? 4'd1 : 4'd2;
  localparam logic [3:0] H1_RST     = (HOUR_MODE_12 != 0) ? 4'd1 : 4'd0;
  localparam logic [3:0] H0_RST     = (HOUR_MODE_12 != 0) ? 4'd2 : 4'd0;

  if (REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_repeat
    $error("REPEAT_DELAY and REPEAT_RATE must be at least 1");
  end

  state_t     state;
  logic       up_q, down_q, next_q, confirm_q;
  logic       up_e, down_e, next_e, confirm_e;
  logic       up_rep, dn_rep;
  logic       up_req, dn_req, step_inc, step_dec, exit_req;
  logic [3:0] cur, lo, hi, stepped, h0_fix;

  // Wrap-around single-digit step; out-of-range values fold back into range.
  function automatic logic [3:0] wrap_step(input logic [3:0] v, input logic [3:0] vlo,
                                           input logic [3:0] vhi, input logic inc);
    if (inc) return (v >= vhi) ? vlo : v + 4'd1;
    else     return (v <= vlo) ? vhi : v - 4'd1;
  endfunction

  assign up_e      = up & ~up_q;
  assign down_e    = down & ~down_q;
  assign next_e    = nextDigit & ~next_q;
  assign confirm_e = confirm & ~confirm_q;
  assign exit_req  = confirm_e | (next_e & (digit_sel == LAST_DIGIT));
  assign up_req    = up_e | up_rep;
  assign dn_req    = down_e | dn_rep;
  assign step_inc  = up_req & ~dn_req;
  assign step_dec  = dn_req & ~up_req;

`ifdef AUTO_REPEAT_EN
  localparam int CW = $clog2(REPEAT_DELAY + REPEAT_RATE + 1);
  logic [CW-1:0] up_cnt, dn_cnt;
  logic          up_arm, dn_arm;

  assign up_rep = up_arm & up & ~down & (up_cnt == '0);
  assign dn_rep = dn_arm & down & ~up & (dn_cnt == '0);

  // Held-button repeat timers: armed by the initial edge, cleared on release, digit change, exit or both buttons.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      up_arm <= 1'b0;
      up_cnt <= '0;
      dn_arm <= 1'b0;
      dn_cnt <= '0;
    end else begin
      if (state != EDIT || !up || down || next_e || confirm_e) begin
        up_arm <= 1'b0;
        up_cnt <= '0;
      end else if (up_e) begin
        up_arm <= 1'b1;
        up_cnt <= CW'(REPEAT_DELAY - 1);
      end else if (up_arm) begin
        up_cnt <= (up_cnt == '0) ? CW'(REPEAT_RATE - 1) : up_cnt - CW'(1);
      end
      if (state != EDIT || !down || up || next_e || confirm_e) begin
        dn_arm <= 1'b0;
        dn_cnt <= '0;
      end else if (down_e) begin
        dn_arm <= 1'b1;
        dn_cnt <= CW'(REPEAT_DELAY - 1);
      end else if (dn_arm) begin
        dn_cnt <= (dn_cnt == '0) ? CW'(REPEAT_RATE - 1) : dn_cnt - CW'(1);
      end
    end
  end
`else
  assign up_rep = 1'b0;
  assign dn_rep = 1'b0;
`endif

  // Legal range of the selected digit, its stepped value, and the h0 clamp when h1 moves.
  always_comb begin
    cur = min0;
    lo  = 4'd0;
    hi  = 4'd9;
    case (digit_sel)
      3'd0: begin
        cur = h1;
        hi  = H1_MAX;
      end
      3'd1: begin
        cur = h0;
        if (HOUR_MODE_12 != 0) begin
          if (h1 == 4'd0) lo = 4'd1;
          else            hi = 4'd2;
        end else begin
          hi = (h1 == 4'd2) ? 4'd3 : 4'd9;
        end
      end
      3'd2: begin
        cur = min1;
        hi  = 4'd5;
      end
      3'd3: cur = min0;
      3'd4: begin
        cur = s1;
        hi  = 4'd5;
      end
      default: cur = s0;
    endcase
    stepped = wrap_step(cur, lo, hi, step_inc);
    h0_fix  = h0;
    if (HOUR_MODE_12 != 0) begin
      if (stepped == 4'd1 && h0 > 4'd2)      h0_fix = 4'd2;
      else if (stepped == 4'd0 && h0 == 4'd0) h0_fix = 4'd1;
    end else if (stepped == 4'd2 && h0 > 4'd3) begin
      h0_fix = 4'd3;
    end
  end

  // Edit FSM with registered outputs; button history is sampled every cycle so presses held across start are not edges.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      editing   <= 1'b0;
      digit_sel <= 3'd0;
      done      <= 1'b0;
      h1        <= H1_RST;
      h0        <= H0_RST;
      min1      <= 4'd0;
      min0      <= 4'd0;
      s1        <= 4'd0;
      s0        <= 4'd0;
      up_q      <= 1'b0;
      down_q    <= 1'b0;
      next_q    <= 1'b0;
      confirm_q <= 1'b0;
    end else begin
      up_q      <= up;
      down_q    <= down;
      next_q    <= nextDigit;
      confirm_q <= confirm;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= EDIT;
            editing   <= 1'b1;
            digit_sel <= 3'd0;
          end
        end
        default: begin
          if (exit_req) begin
            state     <= IDLE;
            editing   <= 1'b0;
            digit_sel <= 3'd0;
            done      <= 1'b1;
          end else if (next_e) begin
            digit_sel <= digit_sel + 3'd1;
          end else if (step_inc || step_dec) begin
            case (digit_sel)
              3'd0: begin
                h1 <= stepped;
                h0 <= h0_fix;
              end
              3'd1: h0   <= stepped;
              3'd2: min1 <= stepped;
              3'd3: min0 <= stepped;
              3'd4: if (SHOW_SECONDS != 0) s1 <= stepped;
              default: if (SHOW_SECONDS != 0) s0 <= stepped;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_set_time_ext.sv
// Bench for set_time_ext: unit a is 24h with seconds, unit b is 12h without seconds.
// Each unit has its own button set; both share clock and reset.
module tb_set_time_ext;

  localparam logic [4:0] B_UP = 5'b00001;
  localparam logic [4:0] B_DN = 5'b00010;
  localparam logic [4:0] B_NX = 5'b00100;
  localparam logic [4:0] B_CF = 5'b01000;
  localparam logic [4:0] B_ST = 5'b10000;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] start, up, down, nxt, cfm;
  logic [3:0] ah1, ah0, am1, am0, as1, as0;
  logic [3:0] bh1, bh0, bm1, bm0, bs1, bs0;
  logic       aed, adone, bed, bdone;
  logic [2:0] asel, bsel;
  int         checks = 0;
  int         errors = 0;

  wire [23:0] a_t  = {ah1, ah0, am1, am0, as1, as0};
  wire [23:0] b_t  = {bh1, bh0, bm1, bm0, bs1, bs0};
  wire [4:0]  a_st = {aed, asel, adone};
  wire [4:0]  b_st = {bed, bsel, bdone};

  always #5 clk = ~clk;

  set_time_ext #(.SHOW_SECONDS(1), .HOUR_MODE_12(0), .REPEAT_DELAY(50), .REPEAT_RATE(10)) u_a (
    .clk(clk), .reset(reset), .start(start[0]), .up(up[0]), .down(down[0]),
    .nextDigit(nxt[0]), .confirm(cfm[0]),
    .h1(ah1), .h0(ah0), .min1(am1), .min0(am0), .s1(as1), .s0(as0),
    .editing(aed), .digit_sel(asel), .done(adone));

  set_time_ext #(.SHOW_SECONDS(0), .HOUR_MODE_12(1), .REPEAT_DELAY(50), .REPEAT_RATE(10)) u_b (
    .clk(clk), .reset(reset), .start(start[1]), .up(up[1]), .down(down[1]),
    .nextDigit(nxt[1]), .confirm(cfm[1]),
    .h1(bh1), .h0(bh0), .min1(bm1), .min0(bm0), .s1(bs1), .s0(bs0),
    .editing(bed), .digit_sel(bsel), .done(bdone));

  task automatic drive(input int d, input logic [4:0] m);
    start[d] = m[4];
    cfm[d]   = m[3];
    nxt[d]   = m[2];
    down[d]  = m[1];
    up[d]    = m[0];
  endtask

  // One-cycle press; returns at the negedge after the sampling posedge.
  task automatic press(input int d, input logic [4:0] m);
    @(negedge clk);
    drive(d, m);
    @(negedge clk);
    drive(d, 5'b0);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    drive(0, 5'b0);
    drive(1, 5'b0);
    #2 reset = 1'b0;
    #10;
    checks++; if (a_t !== 24'h000000) begin errors++; $display("FAIL reset_a_digits: got %h want %h", a_t, 24'h000000); end
    checks++; if (a_st !== 5'b00000) begin errors++; $display("FAIL reset_a_status: got %b want %b", a_st, 5'b00000); end
    checks++; if (b_t !== 24'h120000) begin errors++; $display("FAIL reset_b_digits: got %h want %h", b_t, 24'h120000); end
    checks++; if (b_st !== 5'b00000) begin errors++; $display("FAIL reset_b_status: got %b want %b", b_st, 5'b00000); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_24h_hours;
    press(0, B_ST);
    checks++; if (a_st !== 5'b10000) begin errors++; $display("FAIL enter_a: got %b want %b", a_st, 5'b10000); end
    press(0, B_UP);
    checks++; if (a_t !== 24'h100000) begin errors++; $display("FAIL h1_up1: got %h want %h", a_t, 24'h100000); end
    press(0, B_UP);
    checks++; if (a_t !== 24'h200000) begin errors++; $display("FAIL h1_up2: got %h want %h", a_t, 24'h200000); end
    press(0, B_UP);
    checks++; if (a_t !== 24'h000000) begin errors++; $display("FAIL h1_wrap: got %h want %h", a_t, 24'h000000); end
    press(0, B_UP);
    press(0, B_NX);
    checks++; if (a_st !== 5'b10010) begin errors++; $display("FAIL sel_h0: got %b want %b", a_st, 5'b10010); end
    repeat (9) press(0, B_UP);
    checks++; if (a_t !== 24'h190000) begin errors++; $display("FAIL h0_nine: got %h want %h", a_t, 24'h190000); end
    press(0, B_CF);
    checks++; if (a_st !== 5'b00001) begin errors++; $display("FAIL confirm_done: got %b want %b", a_st, 5'b00001); end
    press(0, B_ST);
    checks++; if (a_t !== 24'h190000) begin errors++; $display("FAIL keep_digits: got %h want %h", a_t, 24'h190000); end
    press(0, B_UP);
    checks++; if (a_t !== 24'h230000) begin errors++; $display("FAIL h0_clamp24: got %h want %h", a_t, 24'h230000); end
    press(0, B_CF);
  endtask

  task automatic test_no_carry;
    press(0, B_ST);
    press(0, B_NX);
    press(0, B_NX);
    checks++; if (asel !== 3'd2) begin errors++; $display("FAIL sel_min1: got %0d want %0d", asel, 2); end
    press(0, B_DN);
    checks++; if (a_t !== 24'h235000) begin errors++; $display("FAIL min1_down_wrap: got %h want %h", a_t, 24'h235000); end
    press(0, B_NX);
    press(0, B_DN);
    checks++; if (a_t !== 24'h235900) begin errors++; $display("FAIL min0_down_wrap: got %h want %h", a_t, 24'h235900); end
    press(0, B_UP);
    checks++; if (a_t !== 24'h235000) begin errors++; $display("FAIL min0_no_carry: got %h want %h", a_t, 24'h235000); end
    press(0, B_CF);
  endtask

  task automatic test_digit_walk;
    press(0, B_ST);
    for (int i = 1; i <= 5; i++) begin
      press(0, B_NX);
      checks++; if (a_st !== {1'b1, 3'(i), 1'b0}) begin errors++; $display("FAIL walk_a_%0d: got %b want %b", i, a_st, {1'b1, 3'(i), 1'b0}); end
    end
    press(0, B_NX);
    checks++; if (a_st !== 5'b00001) begin errors++; $display("FAIL walk_a_exit: got %b want %b", a_st, 5'b00001); end
    @(negedge clk);
    checks++; if (a_st !== 5'b00000) begin errors++; $display("FAIL walk_a_pulse1: got %b want %b", a_st, 5'b00000); end
    press(1, B_ST);
    for (int i = 1; i <= 3; i++) begin
      press(1, B_NX);
      checks++; if (b_st !== {1'b1, 3'(i), 1'b0}) begin errors++; $display("FAIL walk_b_%0d: got %b want %b", i, b_st, {1'b1, 3'(i), 1'b0}); end
    end
    press(1, B_NX);
    checks++; if (b_st !== 5'b00001) begin errors++; $display("FAIL walk_b_exit: got %b want %b", b_st, 5'b00001); end
    @(negedge clk);
    checks++; if (b_st !== 5'b00000) begin errors++; $display("FAIL walk_b_pulse1: got %b want %b", b_st, 5'b00000); end
  endtask

  task automatic test_simultaneous;
    press(0, B_ST);
    press(0, B_UP | B_DN | B_NX);
    checks++; if (asel !== 3'd1 || a_t !== 24'h235000) begin errors++; $display("FAIL updn_next: got sel %0d %h want sel 1 %h", asel, a_t, 24'h235000); end
    press(0, B_UP | B_DN);
    checks++; if (a_t !== 24'h235000) begin errors++; $display("FAIL updn_cancel: got %h want %h", a_t, 24'h235000); end
    press(0, B_UP | B_NX);
    checks++; if (asel !== 3'd2 || a_t !== 24'h235000) begin errors++; $display("FAIL next_over_up: got sel %0d %h want sel 2 %h", asel, a_t, 24'h235000); end
    press(0, B_CF);
    checks++; if (a_st !== 5'b00001) begin errors++; $display("FAIL confirm_mid: got %b want %b", a_st, 5'b00001); end
  endtask

  task automatic test_12h;
    press(1, B_ST);
    press(1, B_UP);
    checks++; if (b_t !== 24'h020000) begin errors++; $display("FAIL b_h1_wrap: got %h want %h", b_t, 24'h020000); end
    press(1, B_UP);
    checks++; if (b_t !== 24'h120000) begin errors++; $display("FAIL b_h1_up: got %h want %h", b_t, 24'h120000); end
    press(1, B_NX);
    press(1, B_UP);
    checks++; if (b_t !== 24'h100000) begin errors++; $display("FAIL b_h0_wrap_up: got %h want %h", b_t, 24'h100000); end
    press(1, B_DN);
    checks++; if (b_t !== 24'h120000) begin errors++; $display("FAIL b_h0_wrap_dn: got %h want %h", b_t, 24'h120000); end
    press(1, B_DN);
    press(1, B_DN);
    checks++; if (b_t !== 24'h100000) begin errors++; $display("FAIL b_h0_zero: got %h want %h", b_t, 24'h100000); end
    press(1, B_CF);
    press(1, B_ST);
    press(1, B_DN);
    checks++; if (b_t !== 24'h010000) begin errors++; $display("FAIL b_clamp_to1: got %h want %h", b_t, 24'h010000); end
    press(1, B_NX);
    press(1, B_DN);
    checks++; if (b_t !== 24'h090000) begin errors++; $display("FAIL b_h0_lo1_wrap: got %h want %h", b_t, 24'h090000); end
    press(1, B_CF);
    press(1, B_ST);
    press(1, B_UP);
    checks++; if (b_t !== 24'h120000) begin errors++; $display("FAIL b_clamp_to2: got %h want %h", b_t, 24'h120000); end
    press(1, B_CF);
  endtask

  task automatic test_start_held;
    @(negedge clk);
    up[0]    = 1'b1;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    @(negedge clk);
    checks++; if (aed !== 1'b1 || a_t !== 24'h235000) begin errors++; $display("FAIL held_before_start: got ed %b %h want ed 1 %h", aed, a_t, 24'h235000); end
    up[0] = 1'b0;
    press(0, B_UP);
    checks++; if (a_t !== 24'h035000) begin errors++; $display("FAIL repress_after_start: got %h want %h", a_t, 24'h035000); end
    press(0, B_CF);
  endtask

  task automatic test_repeat;
    logic [3:0]  exp_m0;
    logic [23:0] exp_t;
`ifdef AUTO_REPEAT_EN
    exp_m0 = 4'd4;
`else
    exp_m0 = 4'd1;
`endif
    exp_t = {4'd0, 4'd3, 4'd5, exp_m0, 8'h00};
    press(0, B_ST);
    repeat (3) press(0, B_NX);
    checks++; if (asel !== 3'd3) begin errors++; $display("FAIL rep_sel: got %0d want %0d", asel, 3); end
    @(negedge clk);
    up[0] = 1'b1;
    repeat (75) @(negedge clk);
    up[0] = 1'b0;
    checks++; if (a_t !== exp_t) begin errors++; $display("FAIL hold_up_75: got %h want %h", a_t, exp_t); end
    press(0, B_CF);
  endtask

  task automatic test_reset_mid;
    press(0, B_ST);
    press(0, B_UP);
    checks++; if (aed !== 1'b1 || ah1 !== 4'd1) begin errors++; $display("FAIL pre_reset_edit: got ed %b h1 %0d want ed 1 h1 1", aed, ah1); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (a_t !== 24'h000000 || a_st !== 5'b00000) begin errors++; $display("FAIL mid_reset_a: got %h %b want %h %b", a_t, a_st, 24'h000000, 5'b00000); end
    checks++; if (b_t !== 24'h120000) begin errors++; $display("FAIL mid_reset_b: got %h want %h", b_t, 24'h120000); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++; if (a_st !== 5'b00000) begin errors++; $display("FAIL no_done_after_reset: got %b want %b", a_st, 5'b00000); end
  endtask

  initial begin
    test_reset();
    test_24h_hours();
    test_no_carry();
    test_digit_walk();
    test_simultaneous();
    test_12h();
    test_start_held();
    test_repeat();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
